// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule constants, state type and helpers
package aes_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, GEN} state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nw_of(input int key_bits);
        return 4 * (nk_of(key_bits) + 7);
    endfunction

endpackage

// File: rtl/aes_key_expander_sbox.sv
// rtl/aes_key_expander_sbox.sv - combinational AES S-box byte lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] plain,
    output logic [7:0] subst
);

    assign subst = SBOX[plain];

endmodule

// File: rtl/aes_key_expander_param.sv
// rtl/aes_key_expander_param.sv - streaming AES-128/192/256 key schedule with valid/ready key and round-key ports
module aes_key_expander_param
    import aes_pkg::*;
#(
    parameter int KEY_BITS   = 128,
    parameter int LANE_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    abort,
    input  logic [8*LANE_BYTES-1:0] key_in,
    input  logic                    key_valid,
    output logic                    key_ready,
    output logic [8*LANE_BYTES-1:0] rk_data,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [3:0]              rk_round,
    output logic                    rk_last,
    output logic                    busy,
    output logic                    done
);

    localparam int LW  = 8 * LANE_BYTES;
    localparam int NK  = nk_of(KEY_BITS);
    localparam int NW  = nw_of(KEY_BITS);
    localparam int BPW = 4 / LANE_BYTES;
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [5:0] WIN_W  = 6'(NK - 1);
    localparam logic [2:0] LAST_S = 3'(NK - 1);
    localparam logic [1:0] LAST_B = 2'(BPW - 1);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("KEY_BITS must be 128, 192 or 256");
    end
    if (!(LANE_BYTES == 1 || LANE_BYTES == 2 || LANE_BYTES == 4)) begin : g_bad_lane_bytes
        $error("LANE_BYTES must be 1, 2 or 4");
    end

    state_t      state, state_next;
    logic [31:0] win [8];
    logic [5:0]  widx;
    logic [2:0]  slot;
    logic [1:0]  beat;
    logic [7:0]  rcon;

    logic        abort_hit, load_last, word_end, final_word, in_window;
    logic [2:0]  prev_slot;
    logic [31:0] prev_word, old_word, sub_in, sub_out, mix, gen_word, word_sh;

    assign abort_hit  = abort && (state != IDLE);
    assign load_last  = (slot == LAST_S) && (beat == LAST_B);
    assign word_end   = (beat == LAST_B);
    assign final_word = (widx == LAST_W);
    assign in_window  = (widx < WIN_W);

    // The window is a ring of the last Nk words: slot holds w[i-Nk] until w[i] overwrites it.
    assign prev_slot = (slot == 3'd0) ? LAST_S : slot - 3'd1;
    assign prev_word = win[prev_slot];
    assign old_word  = win[slot];
    assign sub_in    = (slot == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .plain (sub_in[8*b +: 8]),
            .subst (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        mix = prev_word;
        if (slot == 3'd0) begin
            mix = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && slot == 3'd4) begin
            mix = sub_out;
        end
        gen_word = old_word ^ mix;
    end

    assign word_sh = win[slot] << (beat * LW);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        rk_valid   = 1'b0;
        busy       = 1'b1;
        rk_data    = '0;
        rk_round   = 4'd0;
        rk_last    = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                busy      = 1'b0;
                if (key_valid) state_next = LOAD;
            end
            LOAD: begin
                key_ready = 1'b1;
                if (key_valid && load_last) state_next = EMIT;
            end
            EMIT: begin
                rk_valid = 1'b1;
                rk_data  = word_sh[31 -: LW];
                rk_round = widx[5:2];
                rk_last  = final_word && word_end;
                if (rk_ready && word_end) begin
                    if (final_word) state_next = IDLE;
                    else if (!in_window) state_next = GEN;
                end
            end
            GEN: begin
                rk_round   = widx[5:2];
                state_next = EMIT;
            end
            default: state_next = IDLE;
        endcase
        if (abort_hit) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            widx <= '0;
            slot <= '0;
            beat <= '0;
            rcon <= RCON_INIT;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                widx <= '0;
                slot <= '0;
                beat <= '0;
                rcon <= RCON_INIT;
            end else begin
                case (state)
                    IDLE, LOAD: begin
                        if (key_valid) begin
                            win[slot] <= 32'({win[slot], key_in});
                            if (beat == LAST_B) begin
                                beat <= '0;
                                if (slot == LAST_S) begin
                                    slot <= '0;
                                    widx <= '0;
                                end else begin
                                    slot <= slot + 3'd1;
                                    widx <= widx + 6'd1;
                                end
                            end else begin
                                beat <= beat + 2'd1;
                            end
                        end
                    end
                    EMIT: begin
                        if (rk_ready) begin
                            if (beat == LAST_B) begin
                                beat <= '0;
                                if (final_word) begin
                                    widx <= '0;
                                    slot <= '0;
                                    rcon <= RCON_INIT;
                                    done <= 1'b1;
                                end else begin
                                    widx <= widx + 6'd1;
                                    slot <= (slot == LAST_S) ? 3'd0 : slot + 3'd1;
                                end
                            end else begin
                                beat <= beat + 2'd1;
                            end
                        end
                    end
                    GEN: begin
                        win[slot] <= gen_word;
                        if (slot == 3'd0) rcon <= xtime(rcon);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander_param.sv
// tb/tb_aes_key_expander_param.sv - scoreboard bench for three key-size/lane configurations
module tb_aes_key_expander_param;

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  round;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] key_in    [3];
    logic        key_valid [3];
    logic        rk_ready  [3];
    logic        abort     [3];

    logic d0_kr, d1_kr, d2_kr, d0_v, d1_v, d2_v, d0_l, d1_l, d2_l;
    logic d0_b, d1_b, d2_b, d0_d, d1_d, d2_d;
    logic [7:0]  d0_data;
    logic [31:0] d1_data;
    logic [15:0] d2_data;
    logic [3:0]  d0_r, d1_r, d2_r;

    aes_key_expander_param #(.KEY_BITS(128), .LANE_BYTES(1)) u_d0 (
        .clk(clk), .rst(rst), .abort(abort[0]), .key_in(key_in[0][7:0]), .key_valid(key_valid[0]),
        .key_ready(d0_kr), .rk_data(d0_data), .rk_valid(d0_v), .rk_ready(rk_ready[0]),
        .rk_round(d0_r), .rk_last(d0_l), .busy(d0_b), .done(d0_d));
    aes_key_expander_param #(.KEY_BITS(192), .LANE_BYTES(4)) u_d1 (
        .clk(clk), .rst(rst), .abort(abort[1]), .key_in(key_in[1][31:0]), .key_valid(key_valid[1]),
        .key_ready(d1_kr), .rk_data(d1_data), .rk_valid(d1_v), .rk_ready(rk_ready[1]),
        .rk_round(d1_r), .rk_last(d1_l), .busy(d1_b), .done(d1_d));
    aes_key_expander_param #(.KEY_BITS(256), .LANE_BYTES(2)) u_d2 (
        .clk(clk), .rst(rst), .abort(abort[2]), .key_in(key_in[2][15:0]), .key_valid(key_valid[2]),
        .key_ready(d2_kr), .rk_data(d2_data), .rk_valid(d2_v), .rk_ready(rk_ready[2]),
        .rk_round(d2_r), .rk_last(d2_l), .busy(d2_b), .done(d2_d));

    logic        mkr [3], mv [3], ml [3], mb [3], md [3];
    logic [31:0] mdata [3];
    logic [3:0]  mr [3];
    always_comb begin
        mkr = '{d0_kr, d1_kr, d2_kr};  mv = '{d0_v, d1_v, d2_v};  ml = '{d0_l, d1_l, d2_l};
        mb  = '{d0_b, d1_b, d2_b};     md = '{d0_d, d1_d, d2_d};  mr = '{d0_r, d1_r, d2_r};
        mdata = '{32'(d0_data), d1_data, 32'(d2_data)};
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int lbw(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 2;
    endfunction

    // Independent S-box: multiplicative inverse in GF(2^8) followed by the affine map.
    logic [7:0] sbt [256];
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00, r, s;
            for (int y = 1; y < 256 && x != 0; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ 8'h63;
            r = inv;
            for (int n = 0; n < 4; n++) begin
                r = {r[6:0], r[7]};
                s ^= r;
            end
            sbt[x] = s;
        end
    endtask
    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbt[v[31:24]], sbt[v[23:16]], sbt[v[15:8]], sbt[v[7:0]]};
    endfunction

    exp_t        q [3][$];
    logic [31:0] rx [3][60];
    int          rxn [3], nbeats [3], ndone [3], bcnt [3];
    logic [31:0] acc [3], hd [3];
    logic [3:0]  hr [3], lastround [3];
    logic        hl [3], stalled [3];

    task automatic build(input int k, input int kb, input logic [255:0] key);
        int nk = kb / 32;
        int nw = 4 * (nk + 7);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            q[k].push_back('{w: w[i], round: 4'(i / 4), last: (i == nw - 1)});
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            if (!mb[k]) bcnt[k] = 0;
            if (stalled[k] && mv[k]) begin
                chk("hold_data", mdata[k], hd[k]);
                chk("hold_round", 32'(mr[k]), 32'(hr[k]));
                chk("hold_last", 32'(ml[k]), 32'(hl[k]));
            end
            if (mv[k] && rk_ready[k]) begin
                acc[k] = (acc[k] << (8 * lbw(k))) | mdata[k];
                bcnt[k]++;
                nbeats[k]++;
                if (ml[k]) lastround[k] = mr[k];
                if (bcnt[k] == 4 / lbw(k)) begin
                    bcnt[k] = 0;
                    chk("sb_queue_empty", 32'(q[k].size() == 0), 32'd0);
                    if (q[k].size() != 0) begin
                        e = q[k].pop_front();
                        chk("word", acc[k], e.w);
                        chk("round", 32'(mr[k]), 32'(e.round));
                        chk("last", 32'(ml[k]), 32'(e.last));
                    end
                    if (rxn[k] < 60) rx[k][rxn[k]] = acc[k];
                    rxn[k]++;
                end else begin
                    chk("last_midword", 32'(ml[k]), 32'd0);
                end
            end
            stalled[k] = mv[k] && !rk_ready[k];
            hd[k] = mdata[k];
            hr[k] = mr[k];
            hl[k] = ml[k];
            if (md[k]) ndone[k]++;
        end
    end

    // brk: 0 full run, 1 abort after 50 accepted beats, 2 reset after 50 accepted beats.
    task automatic run(input int k, input int kb, input logic [255:0] key,
                       input bit stall, input bit hold, input int brk);
        int lb = lbw(k);
        int nb = 0;
        bit fin = 0;
        bit last_seen = 0;
        logic [255:0] tmp;
        build(k, kb, key);
        nbeats[k] = 0;
        ndone[k] = 0;
        rxn[k] = 0;
        for (int j = 0; j < kb / (8 * lb); j++) begin
            tmp = key << (j * 8 * lb);
            key_in[k] = 32'(tmp[255:224] >> (32 - 8 * lb));
            key_valid[k] = 1'b1;
            @(negedge clk);
            chk("key_ready_load", 32'(mkr[k]), 32'd1);
            @(posedge clk);
            #1;
        end
        key_valid[k] = hold;
        key_in[k] = 32'hffff_ffff;
        rk_ready[k] = 1'b1;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) chk("first_beat_latency", 32'(mv[k]), 32'd1);
            if (mv[k]) chk("key_ready_emit", 32'(mkr[k]), 32'd0);
            if (md[k]) begin
                fin = 1;
                chk("key_ready_after_done", 32'(mkr[k]), 32'd1);
            end
            if (mv[k] && rk_ready[k]) begin
                nb++;
                if (ml[k]) last_seen = 1;
            end
            @(posedge clk);
            #1;
            if (last_seen) key_valid[k] = 1'b0;
            rk_ready[k] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (brk != 0 && nb == 50 && !fin) begin
                rk_ready[k] = 1'b0;
                if (brk == 1) abort[k] = 1'b1;
                else rst = 1'b0;
                @(posedge clk);
                #1;
                abort[k] = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                chk("brk_rk_valid", 32'(mv[k]), 32'd0);
                chk("brk_busy", 32'(mb[k]), 32'd0);
                chk("brk_key_ready", 32'(mkr[k]), 32'd1);
                chk("brk_no_done", 32'(md[k]), 32'd0);
                q[k].delete();
                fin = 1;
            end
        end
        if (!fin) chk("run_timeout", 32'd1, 32'd0);
        key_valid[k] = 1'b0;
        rk_ready[k] = 1'b0;
        repeat (3) @(negedge clk);
        if (brk == 0) begin
            chk("done_pulses", 32'(ndone[k]), 32'd1);
            chk("beats", 32'(nbeats[k]), 32'(4 * (kb / 32 + 7) * 4 / lb));
            chk("queue_drained", 32'(q[k].size()), 32'd0);
        end else begin
            chk("brk_done_pulses", 32'(ndone[k]), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        for (int k = 0; k < 3; k++) begin
            key_in[k] = '0; key_valid[k] = 0; rk_ready[k] = 0; abort[k] = 0;
            rxn[k] = 0; nbeats[k] = 0; ndone[k] = 0; bcnt[k] = 0; acc[k] = '0;
            stalled[k] = 0; hd[k] = '0; hr[k] = '0; hl[k] = 0; lastround[k] = '0;
        end
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_key_ready", 32'(d0_kr), 32'd1);
        chk("rst_rk_valid", 32'(d0_v), 32'd0);
        chk("rst_rk_data", 32'(d0_data), 32'd0);
        chk("rst_rk_round", 32'(d0_r), 32'd0);
        chk("rst_rk_last", 32'(d0_l), 32'd0);
        chk("rst_busy", 32'(d0_b), 32'd0);
        chk("rst_done", 32'(d0_d), 32'd0);
        @(posedge clk);
        #1;

        run(0, 128, K128, 0, 0, 0);
        chk("aes128_w4", rx[0][4], 32'ha0fafe17);
        chk("aes128_w43", rx[0][43], 32'hb6630ca6);
        chk("aes128_last_round", 32'(lastround[0]), 32'd10);

        run(1, 192, K192, 0, 0, 0);
        chk("aes192_w6", rx[1][6], 32'hfe0c91f7);
        chk("aes192_w51", rx[1][51], 32'h01002202);
        chk("aes192_last_round", 32'(lastround[1]), 32'd12);

        run(2, 256, K256, 0, 0, 0);
        chk("aes256_w8", rx[2][8], 32'h9ba35411);
        chk("aes256_w12", rx[2][12], 32'ha8b09c1a);
        chk("aes256_w59", rx[2][59], 32'h706c631e);
        chk("aes256_last_round", 32'(lastround[2]), 32'd14);

        run(0, 128, K128, 1, 0, 0);
        chk("stall_w43", rx[0][43], 32'hb6630ca6);

        run(0, 128, K128, 0, 0, 1);
        run(0, 128, K128, 0, 0, 0);
        chk("abort_reload_w4", rx[0][4], 32'ha0fafe17);

        run(0, 128, K128, 0, 0, 2);
        run(0, 128, K128, 0, 0, 0);
        chk("rst_reload_w4", rx[0][4], 32'ha0fafe17);

        run(0, 128, K128, 0, 1, 0);
        chk("hold_kv_w43", rx[0][43], 32'hb6630ca6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_expander_param.md
Name: aes_key_expander_param

Overview:
Parametrised AES key-schedule generator covering AES-128, AES-192 and AES-256 with a configurable lane width. It accepts the cipher key as a stream of beats over a valid/ready handshake. It expands the key word by word on the fly and streams all 4*(Nr+1) round-key words to the round datapath over a second valid/ready handshake, tagged with round number and last flag. It replaces the fixed 128-bit, byte-serial, externally sequenced key-schedule datapath, and carries its own controller.

Parameters:
- KEY_BITS, 128, key size. Legal values are 128, 192 and 256; any other value is an elaboration error. Nk = KEY_BITS/32, Nr = Nk+6, total words NW = 4*(Nr+1), giving 44, 52 or 60.
- LANE_BYTES, 1, bytes per beat on both streams. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 resets.
- abort  in  1  synchronous abandon of the current load or expansion.
- key_in  in  8*LANE_BYTES  key beat. Most-significant byte is the lowest FIPS-197 byte index.
- key_valid  in  1  key beat offered.
- key_ready  out  1  key beat accepted when key_valid && key_ready.
- rk_data  out  8*LANE_BYTES  round-key beat; the high byte of the word goes out first.
- rk_valid  out  1  round-key beat valid.
- rk_ready  in  1  consumer accepts when rk_valid && rk_ready.
- rk_round  out  4  round index of the current word, equal to word_index/4.
- rk_last  out  1  high on the final beat of word NW-1.
- busy  out  1  high in LOAD, EMIT and GEN.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst==0 at a clock edge): state goes to IDLE. rk_valid=0, rk_data=0, rk_round=0, rk_last=0, busy=0, done=0. The word counter is 0 and rcon=0x01. key_ready=1 in the first cycle after reset is released. Reset mid-operation discards all state.
- States and key_ready:
  - IDLE: key_ready=1. The first accepted beat moves the block to LOAD, with that beat counted as beat 1.
  - LOAD: key_ready=1 until KEY_BITS/(8*LANE_BYTES) beats have been accepted. Each complete 32-bit word is written into the Nk-word window.
  - After the last key beat the block enters EMIT. rk_valid rises on the next cycle, so load-to-first-beat latency is 1 cycle.
  - key_ready=0 in EMIT and GEN. key_valid is ignored there.
- EMIT: outputs word w[i] as 4/LANE_BYTES beats. rk_data, rk_round and rk_last hold stable while rk_valid && !rk_ready.
- End of each word: after the last beat of w[i] is accepted:
  - If i+1 < Nk, w[i+1] is already in the window. EMIT continues with no bubble.
  - If Nk <= i+1 < NW, go to GEN for exactly 1 cycle with rk_valid=0. Compute w[i+1] into the window slot (i+1) mod Nk, then return to EMIT.
  - If i == NW-1, go to IDLE. Pulse done for 1 cycle and drop rk_valid on that same cycle.
- GEN arithmetic, with prev = w[i-1] and old = w[i-Nk], both 32 bits:
  - i mod Nk == 0: w[i] = old ^ SubWord(RotWord(prev)) ^ {rcon,24'h0}. rcon is then updated to xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1B,36.
  - Nk==8 and i mod 8 == 4: w[i] = old ^ SubWord(prev).
  - Otherwise: w[i] = old ^ prev.
- rk_round range: rk_round reaches Nr (10, 12 or 14) on the final word. rk_last is asserted only on the final beat of w[NW-1].
- abort: takes effect at the clock edge in any non-IDLE state. The next cycle is IDLE with rk_valid=0 and busy=0, and rcon and counters are reinitialised. done does not pulse. abort in IDLE has no effect.
- Simultaneous events: if rst==0 and abort are both active, reset wins. If abort coincides with the final handshake, abort wins and done does not pulse.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry S-box constant and the xtime function;
  - the rcon initial value;
  - a state enum {IDLE, LOAD, EMIT, GEN};
  - functions nk_of(KEY_BITS) and nw_of(KEY_BITS).
- Sub-module aes_sbox: combinational byte lookup, instantiated 4 times for SubWord.

Test Plan:
- AES-128, LANE_BYTES=1, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 throughout. Expected: w[4]=a0fafe17, w[43]=b6630ca6, 176 output beats, rk_round=10 and rk_last=1 on the final beat, done pulses once.
- AES-192, LANE_BYTES=4, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b. Expected: w[6]=fe0c91f7, w[51]=01002202, rk_round=12 on the last beat.
- AES-256, LANE_BYTES=2, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4. Expected: w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only path), w[59]=706c631e.
- AES-128, random rk_ready stalls. Expected: rk_data, rk_round and rk_last stay stable during stalls, and the word sequence is identical to the unstalled run.
- abort asserted at beat 50 of EMIT, and separately rst=0 at beat 50. Expected: rk_valid=0 the next cycle and key_ready=1 afterwards. A reload then gives w[4]=a0fafe17 (rcon restarted at 01).
- key_valid held high during EMIT. Expected: key_ready=0 and the output stream is unchanged. key_ready=1 only after done.
